seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 189 ++++++++++++++++++
 tb/tb_seq_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request/response handshake.
// Most opcodes finish one cycle after accept. MUL is an iterative
// shift-add that spends WIDTH cycles in BUSY.
//
// Build option: define SEQ_ALU_MUL_EN to include the multiplier and the
// BUSY state. Without it, opcode 10 is reserved.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; accept = in_valid && in_ready
//   opcode              0 ADD 1 SUB 2 AND 3 ORR 4 EOR 5 ADC 6 SBC
//                       7 LSL 8 LSR 9 ASR 10 MUL; 11-15 reserved
//   operand_a/b         source operands (operand_b LSBs also give the shift amount)
//   set_flags           the request writes the flag register
//   out_valid/out_ready response handshake
//   result              operation result, held while out_valid is high
//   flags_out           flag register {N,Z,C,V}
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_ORR = 4'd3,
                         OP_EOR = 4'd4, OP_ADC = 4'd5, OP_SBC = 4'd6, OP_LSL = 4'd7,
                         OP_LSR = 4'd8, OP_ASR = 4'd9;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t state, state_nxt, accept_state;
  logic   accept, is_mul;

  assign out_valid = (state == S_DONE);
  assign in_ready  = rst_n && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0]    arith_b, alu_res;
  logic [WIDTH:0]      sum, lsl_t, lsr_t, asr_t;
  logic signed [WIDTH:0] asr_src;
  logic [SHAMT_W-1:0]  shamt;
  logic                arith_cin, alu_c, alu_v, alu_def;

  assign shamt = operand_b[SHAMT_W-1:0];
  // Each shifter is one bit wider than the operand. The extra bit catches
  // the last bit shifted out, so the carry for n == WIDTH and n > WIDTH
  // comes out right with no special cases.
  assign lsl_t   = {1'b0, operand_a} << shamt;
  assign lsr_t   = {operand_a, 1'b0} >> shamt;
  assign asr_src = {operand_a, 1'b0};
  assign asr_t   = asr_src >>> shamt;

  assign arith_b = (opcode == OP_SUB || opcode == OP_SBC) ? ~operand_b : operand_b;
  always_comb begin
    case (opcode)
      OP_SUB:         arith_cin = 1'b1;
      OP_ADC, OP_SBC: arith_cin = flags_out[1];
      default:        arith_cin = 1'b0;
    endcase
  end
  assign sum = {1'b0, operand_a} + {1'b0, arith_b} + {{WIDTH{1'b0}}, arith_cin};

  always_comb begin
    alu_res = '0;
    alu_c   = flags_out[1];
    alu_v   = flags_out[0];
    alu_def = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operand_a[WIDTH-1] == arith_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND: alu_res = operand_a & operand_b;
      OP_ORR: alu_res = operand_a | operand_b;
      OP_EOR: alu_res = operand_a ^ operand_b;
      OP_LSL: begin
        alu_res = lsl_t[WIDTH-1:0];
        if (shamt != '0) alu_c = lsl_t[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_t[WIDTH:1];
        if (shamt != '0) alu_c = lsr_t[0];
      end
      OP_ASR: begin
        alu_res = asr_t[WIDTH:1];
        if (shamt != '0) alu_c = asr_t[0];
      end
      default: alu_def = 1'b0;  // reserved: result 0, flags untouched
    endcase
  end

  // ---------------- iterative multiplier ----------------
`ifdef SEQ_ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sf;
  } mul_t;

  mul_t             mul;
  logic [WIDTH-1:0] acc_nxt;
  logic             mul_last;

  assign is_mul       = (opcode == OP_MUL);
  assign accept_state = is_mul ? S_BUSY : S_DONE;
  assign acc_nxt      = mul.acc + (mul.mplier[0] ? mul.mcand : '0);
  assign mul_last     = (mul.cnt == CNT_W'(WIDTH - 1));

  // The operands are copied into mul at accept, so changes on the input
  // pins after that cannot disturb the operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) mul <= '0;
    else if (accept && is_mul)
      mul <= '{mcand: operand_a, mplier: operand_b, acc: '0, cnt: '0, sf: set_flags};
    else if (state == S_BUSY) begin
      mul.mcand  <= mul.mcand << 1;
      mul.mplier <= mul.mplier >> 1;
      mul.acc    <= acc_nxt;
      mul.cnt    <= mul.cnt + CNT_W'(1);
    end
  end
`else
  assign is_mul       = 1'b0;
  assign accept_state = S_DONE;
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = accept_state;
      S_DONE: begin
        // A new request can be accepted in the same cycle the current result
        // retires, so a stream of requests runs with no idle cycle between them.
        if (accept)         state_nxt = accept_state;
        else if (out_ready) state_nxt = S_IDLE;
      end
`ifdef SEQ_ALU_MUL_EN
      S_BUSY: if (mul_last) state_nxt = S_DONE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- result / flag registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      flags_out <= '0;
    end else begin
      if (accept && !is_mul) begin
        result <= alu_res;
        if (set_flags && alu_def)
          flags_out <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
      end
`ifdef SEQ_ALU_MUL_EN
      if (state == S_BUSY && mul_last) begin
        result <= acc_nxt;
        if (mul.sf) flags_out <= {acc_nxt[WIDTH-1], acc_nxt == '0, flags_out[1:0]};
      end
`endif
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH = 32. Inputs change just after posedge
// or at negedge; outputs are sampled at negedge.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'd0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         set_flags = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [3:0]   flags_out;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(W), .SHAMT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .set_flags(set_flags), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  // Present one request in IDLE, then scramble the inputs once it is accepted.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sf);
    @(negedge clk);
    opcode = op; operand_a = a; operand_b = b; set_flags = sf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = 4'hE; operand_a = 32'hDEADBEEF; operand_b = 32'h0BADF00D;
    set_flags = ~sf;
  endtask

  task automatic retire;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL rst_result: got %h want 0", result); end
    n_cmp++; if (flags_out !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", flags_out); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_arith;
    logic [3:0] vop [7] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd6, 4'd0, 4'd5};
    logic [W-1:0] va [7] = '{32'h7FFFFFFF, 32'd5, 32'd1, 32'h80000000, 32'd3, 32'd1, 32'hFFFFFFFF};
    logic [W-1:0] vb [7] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd1, 32'd2, 32'd0};
    logic         vs [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] vr [7] = '{32'h80000000, 32'd0, 32'd3, 32'h7FFFFFFE, 32'd2, 32'd3, 32'd0};
    logic [3:0]   vf [7] = '{4'b1001, 4'b0110, 4'b0000, 4'b0011, 4'b0010, 4'b0010, 4'b0110};
    for (int i = 0; i < 7; i++) begin
      issue(vop[i], va[i], vb[i], vs[i]);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arith[%0d] out_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (result !== vr[i]) begin n_bad++; $display("FAIL arith[%0d] result: got %h want %h", i, result, vr[i]); end
      n_cmp++; if (flags_out !== vf[i]) begin n_bad++; $display("FAIL arith[%0d] flags: got %b want %b", i, flags_out, vf[i]); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL arith[%0d] in_ready: got %b want 0", i, in_ready); end
      retire();
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arith retire out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_logic;
    logic [3:0]   vop [4] = '{4'd2, 4'd4, 4'd3, 4'd3};
    logic [W-1:0] va [4] = '{32'hF0F00000, 32'h12345678, 32'h00FF0000, 32'd0};
    logic [W-1:0] vb [4] = '{32'hFF000000, 32'h12345678, 32'h0000FF00, 32'd0};
    logic         vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] vr [4] = '{32'hF0000000, 32'd0, 32'h00FFFF00, 32'd0};
    logic [3:0]   vf [4] = '{4'b1010, 4'b0110, 4'b0010, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      issue(vop[i], va[i], vb[i], vs[i]);
      @(negedge clk);
      n_cmp++; if (result !== vr[i]) begin n_bad++; $display("FAIL logic[%0d] result: got %h want %h", i, result, vr[i]); end
      n_cmp++; if (flags_out !== vf[i]) begin n_bad++; $display("FAIL logic[%0d] flags: got %b want %b", i, flags_out, vf[i]); end
      retire();
    end
  endtask

  task automatic test_shift;
    logic [3:0]   vop [10] = '{4'd7, 4'd8, 4'd9, 4'd7, 4'd7, 4'd8, 4'd9, 4'd8, 4'd7, 4'd9};
    logic [W-1:0] va [10] = '{32'h80000001, 32'h80000000, 32'h80000000, 32'h00001234, 32'd1,
                              32'h18, 32'h40000000, 32'd1, 32'd3, 32'h80000010};
    logic [W-1:0] vb [10] = '{32'd1, 32'd32, 32'd40, 32'd0, 32'd33, 32'd4, 32'd40, 32'h100, 32'd31, 32'd4};
    logic [W-1:0] vr [10] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'h00001234, 32'd0,
                              32'd1, 32'd0, 32'd1, 32'h80000000, 32'hF8000001};
    logic [3:0]   vf [10] = '{4'b0010, 4'b0110, 4'b1010, 4'b0010, 4'b0100,
                              4'b0010, 4'b0100, 4'b0000, 4'b1010, 4'b1000};
    for (int i = 0; i < 10; i++) begin
      issue(vop[i], va[i], vb[i], 1'b1);
      @(negedge clk);
      n_cmp++; if (result !== vr[i]) begin n_bad++; $display("FAIL shift[%0d] result: got %h want %h", i, result, vr[i]); end
      n_cmp++; if (flags_out !== vf[i]) begin n_bad++; $display("FAIL shift[%0d] flags: got %b want %b", i, flags_out, vf[i]); end
      retire();
    end
  endtask

  task automatic test_reserved;
`ifdef SEQ_ALU_MUL_EN
    localparam int N = 2;
    logic [3:0] vop [N] = '{4'd11, 4'd15};
`else
    localparam int N = 3;
    logic [3:0] vop [N] = '{4'd11, 4'd15, 4'd10};
`endif
    for (int i = 0; i < N; i++) begin
      issue(vop[i], 32'd3, 32'd4, 1'b1);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rsv[%0d] out_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL rsv[%0d] result: got %h want 0", i, result); end
      n_cmp++; if (flags_out !== 4'b1000) begin n_bad++; $display("FAIL rsv[%0d] flags: got %b want 1000", i, flags_out); end
      retire();
    end
  endtask

  task automatic test_back_to_back;
    issue(4'd0, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    n_cmp++; if (result !== 32'd3) begin n_bad++; $display("FAIL b2b first result: got %h want 3", result); end
    out_ready = 1'b1; in_valid = 1'b1; opcode = 4'd0; operand_a = 32'd10; operand_b = 32'd20;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b out_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 32'd30) begin n_bad++; $display("FAIL b2b second result: got %h want 1e", result); end
    retire();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b idle out_valid: got %b want 0", out_valid); end
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic test_mul;
    logic [W-1:0] va [3] = '{32'h00010000, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] vb [3] = '{32'h00010001, 32'hFFFFFFFF, 32'd2};
    logic [W-1:0] vr [3] = '{32'h00010000, 32'd1, 32'd0};
    logic [3:0]   vf [3] = '{4'b0010, 4'b0010, 4'b0110};
    int busy, ir_bad;
    issue(4'd1, 32'd5, 32'd5, 1'b1);  // flags 0110: C=1, V=0 must survive MUL
    retire();
    for (int i = 0; i < 3; i++) begin
      issue(4'd10, va[i], vb[i], 1'b1);
      busy = 0; ir_bad = 0;
      while (busy < 100) begin
        @(negedge clk);
        if (out_valid === 1'b1) break;
        if (in_ready !== 1'b0) ir_bad++;
        busy++;
      end
      n_cmp++; if (busy != 32) begin n_bad++; $display("FAIL mul[%0d] busy_cycles: got %0d want 32", i, busy); end
      n_cmp++; if (ir_bad != 0) begin n_bad++; $display("FAIL mul[%0d] busy_in_ready: got %0d high want 0", i, ir_bad); end
      n_cmp++; if (result !== vr[i]) begin n_bad++; $display("FAIL mul[%0d] result: got %h want %h", i, result, vr[i]); end
      n_cmp++; if (flags_out !== vf[i]) begin n_bad++; $display("FAIL mul[%0d] flags: got %b want %b", i, flags_out, vf[i]); end
      retire();
    end
  endtask
`endif

  task automatic test_hold_abort;
    int ov_seen;
    issue(4'd0, 32'h80000000, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold[%0d] out_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (result !== 32'h80000000) begin n_bad++; $display("FAIL hold[%0d] result: got %h want 80000000", i, result); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold[%0d] in_ready: got %b want 0", i, in_ready); end
    end
    n_cmp++; if (flags_out !== 4'b1000) begin n_bad++; $display("FAIL hold flags: got %b want 1000", flags_out); end
`ifdef SEQ_ALU_MUL_EN
    retire();
    issue(4'd10, 32'd7, 32'd9, 1'b1);
    repeat (5) @(negedge clk);
`endif
    // Abort: mid-MUL when the multiplier is built in, otherwise in DONE.
    rst_n = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL abort in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort out_valid: got %b want 0", out_valid); end
    n_cmp++; if (flags_out !== 4'b0000) begin n_bad++; $display("FAIL abort flags: got %b want 0000", flags_out); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL abort result: got %h want 0", result); end
    ov_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || flags_out !== 4'b0000) ov_seen++;
    end
    n_cmp++; if (ov_seen != 0) begin n_bad++; $display("FAIL abort late_output: got %0d cycles want 0", ov_seen); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_reserved();
    test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
    test_mul();
`endif
    test_hold_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end
endmodule
